// File: rtl/dsp_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dsp_pkg
// Shared constants for the DSP subtraction pipeline.
//   DSP_WIDTH   : default difference / subtrahend width (minuend is one wider)
//   PIPE_STAGES : number of register slices between operand input and result
//   UFLOW_CNT_W : width of the saturating underflow event counter
// ---------------------------------------------------------------------------
package dsp_pkg;
    localparam int DSP_WIDTH   = 18;
    localparam int PIPE_STAGES = 3;
    localparam int UFLOW_CNT_W = 16;
endpackage

// File: rtl/dsp_pipe_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dsp_pipe_stage
// One valid/ready register slice. The slice loads when it is empty or when
// its current content is taken downstream in the same cycle, so bubbles
// collapse and a full pipeline still moves one item per cycle.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid_i/ready_o : upstream handshake
//   in_data_i          : upstream payload (DW bits)
//   out_valid_o/ready_i: downstream handshake
//   out_data_o         : registered payload, held while stalled, 0 in reset
// ---------------------------------------------------------------------------
module dsp_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/dsp_subtraction.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dsp_subtraction
// Three-stage pipelined subtractor shaped for a DSP48 slice:
//   S1 operand register (A/B), S2 difference register (M/C), S3 output (P).
// diff = minuend - subtrahend with underflow/overflow flags, optional clamp,
// and a saturating count of delivered underflow results.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid, in_ready    : operand handshake
//   minuend [WIDTH:0]     : unsigned minuend (one bit wider than the result)
//   subtrahend [WIDTH-1:0]: unsigned subtrahend
//   out_valid, out_ready  : result handshake
//   diff, underflow, overflow : result and range flags
//   uflow_cnt             : delivered-underflow count, sticks at all-ones
//   cnt_clr               : synchronous clear of uflow_cnt (beats increment)
// ---------------------------------------------------------------------------
module dsp_subtraction
    import dsp_pkg::*;
#(
    parameter int WIDTH    = DSP_WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH:0]         minuend,
    input  logic [WIDTH-1:0]       subtrahend,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       diff,
    output logic                   underflow,
    output logic                   overflow,
    output logic [UFLOW_CNT_W-1:0] uflow_cnt,
    input  logic                   cnt_clr
);
    localparam int S1_W = 2 * WIDTH + 1;
    localparam int S2_W = WIDTH + 2;
    localparam int S3_W = WIDTH + 2;

    // Holds in_ready low until the first clock edge after reset release.
    logic alive_q;

    logic            s1_in_ready, s1_valid, s2_in_ready, s2_valid, s3_in_ready, s3_valid;
    logic [S1_W-1:0] s1_data;
    logic [S2_W-1:0] s2_in_data, s2_data;
    logic [S3_W-1:0] s3_in_data, s3_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign in_ready = alive_q && s1_in_ready;

    dsp_pipe_stage #(.DW(S1_W)) u_s1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid && alive_q),
        .in_ready_o  (s1_in_ready),
        .in_data_i   ({minuend, subtrahend}),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_in_ready),
        .out_data_o  (s1_data)
    );

    // Both operands zero-extended to WIDTH+2 so the sign bit of the result
    // is a clean underflow indicator; this is the only arithmetic between
    // S1 and S2 so it folds into the DSP pre-adder/ALU.
    assign s2_in_data = {1'b0, s1_data[S1_W-1:WIDTH]} - {2'b00, s1_data[WIDTH-1:0]};

    dsp_pipe_stage #(.DW(S2_W)) u_s2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_in_ready),
        .in_data_i   (s2_in_data),
        .out_valid_o (s2_valid),
        .out_ready_i (s3_in_ready),
        .out_data_o  (s2_data)
    );

    // Range classification and optional clamp on the registered difference.
    logic             s2_neg, s2_ovf;
    logic [WIDTH-1:0] s2_res;

    always_comb begin
        s2_neg = s2_data[WIDTH+1];
        s2_ovf = !s2_data[WIDTH+1] && s2_data[WIDTH];
        s2_res = s2_data[WIDTH-1:0];
        if (SATURATE) begin
            if (s2_neg) begin
                s2_res = '0;
            end else if (s2_ovf) begin
                s2_res = '1;
            end
        end
    end

    assign s3_in_data = {s2_neg, s2_ovf, s2_res};

    dsp_pipe_stage #(.DW(S3_W)) u_s3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (s2_valid),
        .in_ready_o  (s3_in_ready),
        .in_data_i   (s3_in_data),
        .out_valid_o (s3_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s3_data)
    );

    assign out_valid = s3_valid;
    assign underflow = s3_data[WIDTH+1];
    assign overflow  = s3_data[WIDTH];
    assign diff      = s3_data[WIDTH-1:0];

    logic [UFLOW_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (s3_valid && out_ready && underflow && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign uflow_cnt = cnt_q;
endmodule

// File: tb/tb_dsp_subtraction.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_dsp_subtraction
// Two instances (wrap and clamp) share one stimulus stream. The driver pushes
// hand-computed expectations into per-instance queues on each input
// handshake; independent monitors pop and compare on each output handshake.
// ---------------------------------------------------------------------------
module tb_dsp_subtraction;
    typedef struct {
        logic [17:0] d;
        logic        uf;
        logic        of;
        bit          lat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [18:0] minuend;
    logic [17:0] subtrahend;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready0, out_valid0, uf0, of0;
    logic [17:0] diff0;
    logic [15:0] cnt0;
    logic        in_ready1, out_valid1, uf1, of1;
    logic [17:0] diff1;
    logic [15:0] cnt1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_cnt = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [17:0] exp_d0, exp_d1;
    logic        exp_uf, exp_of;
    bit          exp_lat;

    bit          hold_v[2];
    logic [19:0] hold_val[2];

    always #5 clk = ~clk;

    dsp_subtraction #(.WIDTH(18), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .minuend(minuend), .subtrahend(subtrahend), .out_valid(out_valid0),
        .out_ready(out_ready), .diff(diff0), .underflow(uf0), .overflow(of0),
        .uflow_cnt(cnt0), .cnt_clr(cnt_clr)
    );

    dsp_subtraction #(.WIDTH(18), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .minuend(minuend), .subtrahend(subtrahend), .out_valid(out_valid1),
        .out_ready(out_ready), .diff(diff1), .underflow(uf1), .overflow(of1),
        .uflow_cnt(cnt1), .cnt_clr(cnt_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard push: one entry per accepted operand pair.
    initial forever begin
        @(negedge clk);
        if (rst_n && in_valid && in_ready0) begin
            exp_t e;
            e.uf = exp_uf; e.of = exp_of; e.lat = exp_lat; e.cyc = cyc;
            e.d = exp_d0; q0.push_back(e);
            e.d = exp_d1; q1.push_back(e);
            acc_cnt++;
            $display("IN  m=%0d s=%0d exp_wrap=%0d exp_sat=%0d uf=%0b of=%0b", minuend, subtrahend, exp_d0, exp_d1, exp_uf, exp_of);
        end
    end

    task automatic mon(input int w, input logic ov, input logic [17:0] d, input logic uf, input logic of);
        exp_t e;
        if (hold_v[w]) begin
            chk($sformatf("stall_hold%0d", w), {12'd0, hold_val[w]}, {12'd0, uf, of, d});
        end
        hold_v[w]   = ov && !out_ready;
        hold_val[w] = {uf, of, d};
        if (ov && out_ready) begin
            if (w == 0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_out0", 32'd1, 32'd0);
                    return;
                end
                e = q0.pop_front();
            end else begin
                if (q1.size() == 0) begin
                    chk("unexpected_out1", 32'd1, 32'd0);
                    return;
                end
                e = q1.pop_front();
            end
            $display("OUT%0d diff=%0d uf=%0b of=%0b exp=%0d/%0b/%0b lat=%0d", w, d, uf, of, e.d, e.uf, e.of, cyc - e.cyc);
            chk($sformatf("result%0d", w), {12'd0, uf, of, d}, {12'd0, e.uf, e.of, e.d});
            if (e.lat) chk($sformatf("latency%0d", w), cyc - e.cyc, 32'd3);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            mon(0, out_valid0, diff0, uf0, of0);
            mon(1, out_valid1, diff1, uf1, of1);
        end else begin
            hold_v[0] = 1'b0;
            hold_v[1] = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [18:0] m, input logic [17:0] s, input logic [17:0] d0,
                        input logic [17:0] d1, input logic uf, input logic of, input bit lat);
        bit hs = 1'b0;
        int n  = 0;
        minuend = m; subtrahend = s;
        exp_d0 = d0; exp_d1 = d1; exp_uf = uf; exp_of = of; exp_lat = lat;
        in_valid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = in_ready0;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!hs) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || out_valid0 || out_valid1) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_q0", q0.size(), 32'd0);
        chk("drain_q1", q1.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; minuend = '0; subtrahend = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        exp_d0 = '0; exp_d1 = '0; exp_uf = 1'b0; exp_of = 1'b0; exp_lat = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_diff", {14'd0, diff0}, 32'd0);
        chk("rst_flags", {30'd0, uf0, of0}, 32'd0);
        chk("rst_cnt", {16'd0, cnt0}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready0}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", {31'd0, in_ready0}, 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", {31'd0, in_ready0}, 32'd1);

        // Back-to-back in-range vectors, then range boundaries.
        send(19'd300,    18'd200,   18'd100,    18'd100,    1'b0, 1'b0, 1'b1);
        send(19'd75000,  18'd45000, 18'd30000,  18'd30000,  1'b0, 1'b0, 1'b1);
        send(19'd65536,  18'd1,     18'd65535,  18'd65535,  1'b0, 1'b0, 1'b1);
        send(19'd100,    18'd200,   18'd262044, 18'd0,      1'b1, 1'b0, 1'b1);
        send(19'd524287, 18'd0,     18'd262143, 18'd262143, 1'b0, 1'b1, 1'b1);
        send(19'd262144, 18'd0,     18'd0,      18'd262143, 1'b0, 1'b1, 1'b1);
        send(19'd262143, 18'd0,     18'd262143, 18'd262143, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: five pairs against a stalled output.
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                send(19'd10,     18'd3,      18'd7,      18'd7,      1'b0, 1'b0, 1'b0);
                send(19'd1000,   18'd1,      18'd999,    18'd999,    1'b0, 1'b0, 1'b0);
                send(19'd5,      18'd5,      18'd0,      18'd0,      1'b0, 1'b0, 1'b0);
                send(19'd7,      18'd9,      18'd262142, 18'd0,      1'b1, 1'b0, 1'b0);
                send(19'd400000, 18'd200000, 18'd200000, 18'd200000, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("stall_accepted", acc_cnt, 32'd3);
                chk("stall_in_ready", {31'd0, in_ready0}, 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two results in flight (one in S3, one in S2).
        send(19'd1, 18'd1, 18'd0, 18'd0, 1'b0, 1'b0, 1'b0);
        send(19'd2, 18'd1, 18'd1, 18'd1, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", {31'd0, out_valid0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid0", {31'd0, out_valid0}, 32'd0);
        chk("midrst_out_valid1", {31'd0, out_valid1}, 32'd0);
        chk("midrst_diff", {14'd0, diff0}, 32'd0);
        q0.delete();
        q1.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(19'd50, 18'd20, 18'd30, 18'd30, 1'b0, 1'b0, 1'b1);
        drain();

        // Underflow counter with clear colliding with an increment.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("cnt_cleared", {16'd0, cnt0}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(19'd0, 18'd1, 18'd262143, 18'd0, 1'b1, 1'b0, 1'b1);
        end
        drain();
        chk("cnt_three0", {16'd0, cnt0}, 32'd3);
        chk("cnt_three1", {16'd0, cnt1}, 32'd3);
        out_ready = 1'b0;
        send(19'd0, 18'd1, 18'd262143, 18'd0, 1'b1, 1'b0, 1'b0);
        begin
            int n = 0;
            while (!(out_valid0 && out_valid1) && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("fourth_at_output", {31'd0, out_valid0}, 32'd1);
        end
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("cnt_clr_wins0", {16'd0, cnt0}, 32'd0);
        chk("cnt_clr_wins1", {16'd0, cnt1}, 32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dsp_subtraction.md
DSP_SUBTRACTION -- requirements
Module: dsp_subtraction

Interface
REQ-001 The module SHALL have parameter WIDTH, default 18, the difference and subtrahend width; the minuend width is WIDTH+1.
REQ-002 The module SHALL have parameter SATURATE, default 0: 0 = wrap out-of-range results, 1 = clamp them.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock, all logic rising-edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit, operand pair valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit, operand pair accepted this cycle when in_valid is also high.
REQ-007 The module SHALL have port minuend, input, WIDTH+1 bits, unsigned.
REQ-008 The module SHALL have port subtrahend, input, WIDTH bits, unsigned.
REQ-009 The module SHALL have port out_valid, output, 1 bit, result valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit, downstream accepts the result.
REQ-011 The module SHALL have port diff, output, WIDTH bits, the result.
REQ-012 The module SHALL have port underflow, output, 1 bit, set when minuend < subtrahend.
REQ-013 The module SHALL have port overflow, output, 1 bit, set when minuend - subtrahend > 2^WIDTH-1.
REQ-014 The module SHALL have port uflow_cnt, output, 16 bits, count of delivered results that had underflow set, saturating at 65535.
REQ-015 The module SHALL have port cnt_clr, input, 1 bit, synchronous clear of uflow_cnt.

Function
REQ-016 The pipeline SHALL have three register stages (S1: operand register, S2: subtract register, S3: output register, matching DSP48 A/B, M/C and P registers), each with its own valid bit.
REQ-017 Latency SHALL be exactly 3 cycles from input handshake to out_valid when out_ready is held high.
REQ-018 A stage SHALL load when it is empty or its content moves downstream in the same cycle.
REQ-019 in_ready SHALL equal S1-loadable; bubbles SHALL collapse, so an empty S2 accepts from S1 even while S3 stalls.
REQ-020 With out_ready high and continuous in_valid, throughput SHALL be one result per cycle.
REQ-021 While out_valid is high and out_ready is low, diff, underflow and overflow SHALL hold stable.
REQ-022 S2 SHALL compute a signed WIDTH+2-bit difference, minuend - subtrahend.
REQ-023 underflow SHALL be set when the S2 difference is negative.
REQ-024 overflow SHALL be set when bit WIDTH of the S2 difference is set and the difference is non-negative; underflow and overflow SHALL never both be set.
REQ-025 With SATURATE=0, diff SHALL be the low WIDTH bits of the difference; with SATURATE=1, diff SHALL be 0 on underflow and 2^WIDTH-1 on overflow.
REQ-026 uflow_cnt SHALL increment when an underflow result completes the out_valid&&out_ready handshake.
REQ-027 When cnt_clr coincides with an increment, clear SHALL win and uflow_cnt SHALL become 0.
REQ-028 Operand pairs SHALL never be dropped, duplicated or reordered under any out_ready pattern.

Reset
REQ-029 Asserting rst_n low SHALL immediately clear all stage valid bits and force out_valid=0, diff=0, underflow=0, overflow=0 and uflow_cnt=0.
REQ-030 During reset, in_ready SHALL be 0; it SHALL become 1 on the first clock edge after deassertion.
REQ-031 Reset mid-operation SHALL discard all in-flight results without emitting them.

Structure
REQ-032 Package dsp_pkg SHALL hold DSP_WIDTH=18, PIPE_STAGES=3 and UFLOW_CNT_W=16.
REQ-033 A single sub-module dsp_pipe_stage (one valid/ready register slice, data width parameterised) SHALL be instantiated three times.
REQ-034 The subtract logic SHALL sit between S1 and S2 so that synthesis maps it to one DSP48 slice.

Verification
REQ-035 The bench SHALL drive 300-200, 75000-45000 and 65536-1 back-to-back with out_ready=1, requiring diff = 100, 30000 and 65535 on three consecutive cycles starting 3 cycles after the first handshake, with no flags set.
REQ-036 The bench SHALL drive 100-200 with SATURATE=0, requiring diff=262044 and underflow=1, and with SATURATE=1, requiring diff=0 and underflow=1.
REQ-037 The bench SHALL drive 524287-0, requiring overflow=1 and diff=262143 in both SATURATE modes.
REQ-038 The bench SHALL stream 5 pairs with out_ready=0 for 6 cycles, requiring in_ready to fall after 3 accepted pairs and all 5 results to emerge in order once out_ready=1.
REQ-039 The bench SHALL pulse rst_n low with 2 results in flight, requiring out_valid=0 at once, no stale result afterwards, and the next input to return after 3 cycles.
REQ-040 The bench SHALL send 3 underflow results, then assert cnt_clr together with a 4th underflow handshake, requiring uflow_cnt to read 3 and then 0.
